bitty_sequencer: RTL and testbench
==================================

BITTY_SEQUENCER -- requirements
Module: bitty_sequencer

Interface
REQ-001 Parameter ADDR_W, 8, program-counter and instruction-memory address width.
REQ-002 Parameter MEM_TIMEOUT, 15, maximum cycles to wait for mem_valid before raising fault.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, a one-cycle pulse in IDLE begins execution from address 0.
REQ-006 Port mem_rd_en, output, 1, instruction-memory read request, held until mem_valid.
REQ-007 Port mem_addr, output, ADDR_W, read address, equal to pc while mem_rd_en=1.
REQ-008 Port mem_rdata, input, 16, instruction word, sampled only when mem_valid=1.
REQ-009 Port mem_valid, input, 1, read-data-valid strobe, with a latency of 1 or more cycles.
REQ-010 Port d_inst, output, 16, registered instruction presented to the CPU; stable from the run pulse until the CPU asserts done.
REQ-011 Port run, output, 1, one-cycle pulse that launches the CPU on d_inst.
REQ-012 Port done, input, 1, CPU completion strobe.
REQ-013 Port flags, input, 3, ALU compare result {lt,gt,eq}, sampled in BRANCH.
REQ-014 Port pc, output, ADDR_W, current program counter.
REQ-015 Port busy, output, 1, high in every state except IDLE and HALT.
REQ-016 Port halted, output, 1, high in HALT.
REQ-017 Port fault, output, 1, sticky memory-timeout flag; cleared only by reset.
REQ-018 Port inst_count, output, 16, number of retired instructions; saturates at 16'hFFFF.

Function
REQ-019 FSM states: IDLE, FETCH, EXEC, WAIT_DONE, BRANCH, HALT.
REQ-020 IDLE: on start=1, set pc=0 and go to FETCH; otherwise stay in IDLE.
REQ-021 FETCH: assert mem_rd_en with mem_addr=pc. On mem_valid=1, latch mem_rdata into d_inst; the next state depends on the word fetched.
REQ-022 FETCH next state: 16'hFFFF goes to HALT; format d_inst[1:0]=2'b10 goes to BRANCH; any other format goes to EXEC.
REQ-023 FETCH timeout: after MEM_TIMEOUT consecutive cycles without mem_valid, set fault=1 and go to HALT.
REQ-024 EXEC: run=1 for exactly one cycle, then go to WAIT_DONE. Total latency from mem_valid to run is 1 cycle.
REQ-025 WAIT_DONE: on done=1, set pc=pc+1 modulo 2^ADDR_W, increment inst_count, and go to FETCH.
REQ-026 BRANCH: the CPU is not launched. Condition field cond=d_inst[3:2] selects the test.
REQ-027 Branch conditions: cond 00 tests eq; 01 tests gt; 10 tests lt; 11 is always taken.
REQ-028 Branch outcome: if taken, pc=d_inst[11:4] (zero-extended or truncated to ADDR_W); otherwise pc=pc+1. Either way, increment inst_count and return to FETCH, spending one cycle in BRANCH.
REQ-029 PC wrap: pc=2^ADDR_W-1 increments to 0 with no fault.
REQ-030 HALT: stay in HALT; start=1 restarts as in REQ-020 and leaves fault unchanged.
REQ-031 Ignored inputs: done outside WAIT_DONE, start outside IDLE/HALT, and mem_valid outside FETCH are all ignored.
REQ-032 Same-cycle done and start: in WAIT_DONE, done takes effect and start is ignored.
REQ-033 Output registration: run, mem_rd_en and d_inst are registered with no combinational path from inputs; mem_addr is driven directly from the pc register.

Reset
REQ-034 While reset=0, regardless of clk: state=IDLE, pc=0, d_inst=0, run=0, mem_rd_en=0, busy=0, halted=0, fault=0, inst_count=0.
REQ-035 Reset asserted mid-fetch or mid-execution aborts immediately, and no run pulse is issued afterward.
REQ-036 Reset deassertion is synchronised externally; the first active edge after release evaluates IDLE.

Structure
REQ-037 Shared package bitty_pkg holds the state encoding, the format codes (FMT_REG=2'b00, FMT_IMM=2'b01, FMT_BR=2'b10), the condition codes, and HALT_WORD=16'hFFFF.
REQ-038 One sub-module, branch_eval, computes the taken bit from cond and flags combinationally; everything else lives in bitty_sequencer.

Verification
REQ-039 Sequential program: memory [0]=16'h0001, [1]=16'h2001, [2]=16'hFFFF; start with done returned 2 cycles after each run. Expect 2 run pulses, d_inst values 0001 then 2001, halted=1, inst_count=2, pc=2.
REQ-040 Taken branch: [0]=16'h0052 (target 5, cond eq), flags=3'b001. Expect no run pulse, next fetch address 5, inst_count=1.
REQ-041 Not-taken branch: same word with flags=3'b010. Expect next fetch address 1.
REQ-042 Memory timeout: mem_valid held at 0 after start. Expect fault=1 and halted=1 after exactly 15 FETCH cycles, with run never asserted.
REQ-043 Reset mid-run: assert reset=0 in WAIT_DONE. Expect all outputs at reset values within the same cycle and no run pulse after release until start.
REQ-044 PC wrap: with ADDR_W=4, 16 non-branch words and no HALT_WORD, expect the 17th fetch at address 0, fault=0, inst_count=16.

Source files
------------

// File: rtl/bitty_pkg.sv
// bitty_pkg: shared state encoding, instruction format/condition codes and helpers for the bitty sequencer
package bitty_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_DONE,
        S_BRANCH,
        S_HALT
    } state_t;
    localparam logic [1:0] FMT_REG = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_BR = 2'b10;
    localparam logic [1:0] COND_EQ = 2'b00;
    localparam logic [1:0] COND_GT = 2'b01;
    localparam logic [1:0] COND_LT = 2'b10;
    localparam logic [1:0] COND_AL = 2'b11;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/branch_eval.sv
// branch_eval: combinational branch decision; cond selects eq/gt/lt/always against flags {lt,gt,eq}, taken is the result
module branch_eval
    import bitty_pkg::*;
(
    input  logic [1:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    always_comb taken = cond == COND_EQ ? flags[0] :
                        cond == COND_GT ? flags[1] :
                        cond == COND_LT ? flags[2] : 1'b1;
endmodule

// File: rtl/bitty_sequencer.sv
// bitty_sequencer: fetch/launch/branch sequencer; clk/reset(async low), start, mem_* fetch port, d_inst/run/done CPU handshake, flags for branches, pc/busy/halted/fault/inst_count status
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       d_inst,
    output logic              run,
    input  logic              done,
    input  logic [2:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       inst_count
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    state_t state;
    logic [TW-1:0] tcnt;
    logic taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    branch_eval u_branch_eval (
        .cond (d_inst[3:2]),
        .flags(flags),
        .taken(taken)
    );
    assign target = ADDR_W'(d_inst[11:4]);
    assign pc_next = pc + ADDR_W'(1);
    assign mem_addr = pc;
    assign busy = state != S_IDLE && state != S_HALT;
    assign halted = state == S_HALT;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc <= '0;
            d_inst <= '0;
            run <= 1'b0;
            mem_rd_en <= 1'b0;
            fault <= 1'b0;
            inst_count <= '0;
            tcnt <= '0;
        end else begin
            run <= 1'b0;
            case (state)
                S_IDLE, S_HALT: if (start) begin
                    pc <= '0;
                    mem_rd_en <= 1'b1;
                    tcnt <= '0;
                    state <= S_FETCH;
                end
                S_FETCH: if (mem_valid) begin
                    d_inst <= mem_rdata;
                    mem_rd_en <= 1'b0;
                    if (mem_rdata == HALT_WORD) begin
                        state <= S_HALT;
                    end else if (mem_rdata[1:0] == FMT_BR) begin
                        state <= S_BRANCH;
                    end else begin
                        // run is raised here so it appears one cycle after mem_valid
                        run <= 1'b1;
                        state <= S_EXEC;
                    end
                end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
                    fault <= 1'b1;
                    mem_rd_en <= 1'b0;
                    state <= S_HALT;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                S_EXEC: state <= S_WAIT_DONE;
                S_WAIT_DONE: if (done) begin
                    pc <= pc_next;
                    inst_count <= sat_inc(inst_count);
                    mem_rd_en <= 1'b1;
                    tcnt <= '0;
                    state <= S_FETCH;
                end
                S_BRANCH: begin
                    pc <= taken ? target : pc_next;
                    inst_count <= sat_inc(inst_count);
                    mem_rd_en <= 1'b1;
                    tcnt <= '0;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitty_sequencer.sv
// tb_bitty_sequencer: scoreboard bench for bitty_sequencer with a memory responder and a CPU done model
module tb_bitty_sequencer;
    localparam int AW = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic mem_valid = 1'b0;
    logic done = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [2:0] flags = '0;
    logic mem_rd_en, run, busy, halted, fault;
    logic [AW-1:0] mem_addr, pc;
    logic [15:0] d_inst, inst_count;
    logic [15:0] mem [16];
    int lat = 1;
    bit mem_en = 1'b1;
    bit cpu_en = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic [AW-1:0] exp_addr [$];
    logic [15:0] exp_inst [$];

    typedef struct {
        logic [15:0]   word;
        logic [2:0]    fl;
        logic [AW-1:0] npc;
    } br_vec_t;
    br_vec_t br_tab [6];

    bitty_sequencer #(.ADDR_W(AW), .MEM_TIMEOUT(15)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .d_inst(d_inst),
        .run(run),
        .done(done),
        .flags(flags),
        .pc(pc),
        .busy(busy),
        .halted(halted),
        .fault(fault),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory responder: answers a pending read after lat cycles with a one-cycle strobe
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en && mem_rd_en && !mem_valid) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[mem_addr];
                    cnt = 0;
                end
            end else begin
                mem_valid = 1'b0;
                if (!mem_rd_en) cnt = 0;
            end
        end
    end

    // CPU model: done two cycles after each run pulse
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_en && run) begin
                repeat (2) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        end
    end

    // monitor: pops expected fetch addresses and launched instructions
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (run) begin
                if (exp_inst.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL run_pulse: unexpected run with d_inst=%h, none required", d_inst);
                end else check("run_d_inst", d_inst, exp_inst.pop_front());
            end
            if (mem_rd_en && !prev) begin
                if (exp_addr.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL fetch: unexpected fetch at %0h, none required", mem_addr);
                end else check("fetch_addr", mem_addr, exp_addr.pop_front());
            end
            prev = mem_rd_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int maxc);
        int n = 0;
        while (!halted && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            compared++;
            mismatched++;
            $display("FAIL wait_halt: halted=0 after %0d cycles, required 1", maxc);
        end
    endtask

    initial begin
        br_tab[0] = '{16'h0052, 3'b001, 4'd5};
        br_tab[1] = '{16'h0052, 3'b010, 4'd1};
        br_tab[2] = '{16'h005A, 3'b100, 4'd5};
        br_tab[3] = '{16'h0056, 3'b010, 4'd5};
        br_tab[4] = '{16'h005E, 3'b000, 4'd5};
        br_tab[5] = '{16'h0056, 3'b101, 4'd1};
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        #12;
        check("rst_run", run, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_count", inst_count, 0);
        check("rst_pc", pc, 0);
        check("rst_d_inst", d_inst, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // sequential program
        lat = 2;
        mem[0] = 16'h0001;
        mem[1] = 16'h2001;
        mem[2] = 16'hFFFF;
        exp_addr = '{4'd0, 4'd1, 4'd2};
        exp_inst = '{16'h0001, 16'h2001};
        pulse_start();
        wait_halt(200);
        check("seq_halted", halted, 1);
        check("seq_count", inst_count, 2);
        check("seq_pc", pc, 2);
        check("seq_fault", fault, 0);
        check("seq_busy", busy, 0);

        // branch table: taken and not-taken for each condition
        lat = 1;
        mem[1] = 16'hFFFF;
        mem[5] = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mem[0] = br_tab[i].word;
            flags = br_tab[i].fl;
            exp_addr.push_back(4'd0);
            exp_addr.push_back(br_tab[i].npc);
            pulse_start();
            wait_halt(100);
            check("br_pc", pc, br_tab[i].npc);
            check("br_count", inst_count, 1);
        end
        flags = 3'b000;

        // fetch timeout, then restart from HALT keeps fault
        do_reset();
        mem_en = 1'b0;
        exp_addr.push_back(4'd0);
        begin
            int n = 0;
            int g = 0;
            pulse_start();
            while (!halted && g < 100) begin
                if (mem_rd_en) n++;
                @(negedge clk);
                g++;
            end
            check("to_fetch_cycles", n, 15);
        end
        check("to_fault", fault, 1);
        check("to_halted", halted, 1);
        check("to_rd_en", mem_rd_en, 0);
        mem_en = 1'b1;
        mem[0] = 16'hFFFF;
        exp_addr.push_back(4'd0);
        pulse_start();
        wait_halt(100);
        check("restart_fault", fault, 1);
        check("restart_count", inst_count, 0);

        // reset in WAIT_DONE
        do_reset();
        check("rst2_fault", fault, 0);
        cpu_en = 1'b0;
        mem[0] = 16'h0001;
        exp_addr.push_back(4'd0);
        exp_inst.push_back(16'h0001);
        pulse_start();
        begin
            int g = 0;
            while (!run && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("mid_run_seen", run, 1);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_run", run, 0);
        check("mid_rd_en", mem_rd_en, 0);
        check("mid_busy", busy, 0);
        check("mid_halted", halted, 0);
        check("mid_pc", pc, 0);
        check("mid_d_inst", d_inst, 0);
        check("mid_count", inst_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cpu_en = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", busy, 0);

        // PC wrap over 16 words
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 16'((i << 8) + 1);
            exp_addr.push_back(AW'(i));
            exp_inst.push_back(16'((i << 8) + 1));
        end
        exp_addr.push_back(4'd0);
        pulse_start();
        begin
            int g = 0;
            while (inst_count == 0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("wrap_first_retire", inst_count, 1);
        end
        mem[0] = 16'hFFFF;
        wait_halt(2000);
        check("wrap_pc", pc, 0);
        check("wrap_count", inst_count, 16);
        check("wrap_fault", fault, 0);

        check("left_fetches", exp_addr.size(), 0);
        check("left_runs", exp_inst.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
